calc_sequencer: RTL
===================

Name: calc_sequencer

Overview:
- Job front-end for the controle FSM and its datapath.
- Accepts one operand word per valid/ready handshake and presents it to the datapath as a stable operand.
- Issues a one-cycle inicio pulse, waits for controle's done, and captures the datapath result into an output register with valid/ready handshake.
- Adds timeout detection and a job counter around controle.

Parameters:
- DW, 8, operand/result width in bits
- TIMEOUT, 32, max cycles in WAIT without done before error (must be >= 12)
- CW, 8, job counter width

Ports:
- ck  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  upstream operand valid
- in_data  in  DW  upstream operand
- in_ready  out  1  block can accept operand this cycle
- x_op  out  DW  operand to datapath, held stable from START until the next accept
- inicio  out  1  start pulse to controle, registered
- done_i  in  1  done from controle
- res_in  in  DW  datapath result, valid in the cycle done_i=1
- out_valid  out  1  result valid
- out_data  out  DW  captured result
- out_ready  in  1  downstream accepts result
- busy  out  1  state is START or WAIT
- err_timeout  out  1  sticky timeout flag
- job_count  out  CW  completed jobs, wraps

Behaviour:
- Reset (rst=0, async): state=IDLE; x_op=0, inicio=0, out_valid=0, out_data=0, err_timeout=0, job_count=0, timer=0.
- All state and outputs are registered, except:
  - in_ready = (state==IDLE) && (!out_valid || out_ready)
  - busy is decoded from state.
- IDLE:
  - Accept when in_valid && in_ready: x_op<=in_data, go to START.
  - done_i is ignored.
- START:
  - inicio=1 for exactly this one cycle.
  - timer<=0, go to WAIT.
  - done_i is ignored.
- WAIT:
  - inicio=0; timer increments each cycle.
  - If done_i=1: out_data<=res_in, out_valid<=1, job_count<=job_count+1 (mod 2^CW), go to IDLE.
  - Else if timer==TIMEOUT-1: err_timeout<=1, go to ERR.
  - If done_i and the timeout occur in the same cycle, done_i wins: the result is captured, no error.
- ERR:
  - in_ready=0, inicio=0; out_valid keeps its handshake behaviour.
  - Exit only via reset.
- Output handshake:
  - out_valid clears on out_valid && out_ready, unless a new result is captured in the same cycle; capture has priority and out_valid stays 1.
  - out_data is stable while out_valid=1 && out_ready=0.
  - A new job cannot start while an unconsumed result is held. Because in_ready requires !out_valid || out_ready, a capture can never overwrite unread data.
- Latency:
  - Accept edge -> inicio high on the next cycle.
  - done_i -> out_valid high on the next cycle.
  - Back-to-back throughput is limited by controle latency.
- Reset mid-job: returns to IDLE immediately, clears all outputs. controle is expected to be reset by the same system reset.
- done_i held high for multiple cycles: only the first cycle in WAIT counts; later cycles are seen in IDLE and ignored.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE=3'd0, START=3'd1, WAIT=3'd2, ERR=3'd3
  - default constants DW=8, TIMEOUT=32.
- No sub-module: FSM, timer and output register live in one module.
- The bench instantiates calc_sequencer with controle and the datapath as a system test, plus a behavioural done_i model for unit tests.

Test Plan:
- Single job: in_data=8'h05, in_valid 1 cycle, model done_i 9 cycles after inicio, res_in=8'h2A, out_ready=1 -> inicio one cycle after accept; out_valid=1 with out_data=8'h2A one cycle after done_i; job_count=1.
- Backpressure: out_ready=0 after result 8'h11, in_valid=1 with 8'h07 -> in_ready=0 and out_data stays 8'h11 for 20 cycles. Raise out_ready -> same-cycle accept of 8'h07, x_op=8'h07 next cycle.
- Timeout: done_i never asserted -> err_timeout=1 exactly TIMEOUT cycles after START, state ERR, in_ready=0. rst=0 then 1 -> err_timeout=0, in_ready=1.
- Done/timeout tie: done_i=1 on cycle TIMEOUT-1 of WAIT with res_in=8'h3C -> out_data=8'h3C, err_timeout=0.
- Reset mid-WAIT: rst=0 for 1 cycle, 4 cycles after inicio -> out_valid=0, job_count=0, inicio=0, state IDLE asynchronously; a later done_i pulse is ignored.
- Counter wrap and stray done: 256 jobs with CW=8 -> job_count wraps to 0. done_i pulsed in IDLE -> no out_valid, no count change.

Source files
------------

// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calc_sequencer job front-end: state encoding and
// default sizing constants.
package calc_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    ERR   = 3'd3
  } seq_state_e;

  localparam int unsigned DW_DEFAULT      = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 32;
  localparam int unsigned CW_DEFAULT      = 8;

endpackage

// File: rtl/calc_sequencer.sv
// Job front-end for controle: takes an operand, pulses inicio, waits for done
// with a timeout, and holds the result behind a valid/ready output register.
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CW      = CW_DEFAULT
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] x_op,
  output logic          inicio,
  input  logic          done_i,
  input  logic [DW-1:0] res_in,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          err_timeout,
  output logic [CW-1:0] job_count
);

  // Timer only needs to reach TIMEOUT-1; it leaves WAIT before overflowing.
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

  seq_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] x_op_q, x_op_d;
  logic          inicio_q, inicio_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          err_q, err_d;
  logic [CW-1:0] job_q, job_d;

  assign in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign busy        = (state_q == START) || (state_q == WAIT);
  assign x_op        = x_op_q;
  assign inicio      = inicio_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign err_timeout = err_q;
  assign job_count   = job_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    x_op_d      = x_op_q;
    inicio_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    err_d       = err_q;
    job_d       = job_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          x_op_d   = in_data;
          inicio_d = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // done beats a same-cycle timeout; capture overrides the handshake clear.
        if (done_i) begin
          out_data_d  = res_in;
          out_valid_d = 1'b1;
          job_d       = job_q + 1'b1;
          state_d     = IDLE;
        end else if (timer_q == TimerLast) begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      x_op_q      <= '0;
      inicio_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      job_q       <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      x_op_q      <= x_op_d;
      inicio_q    <= inicio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      job_q       <= job_d;
    end
  end

endmodule
